// File: rtl/div_restoring_4.sv
// rtl/div_restoring_4.sv - sequential unsigned restoring divider with start/busy/done handshake
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   Start    request, sampled only in IDLE together with A and B
//   A        dividend
//   B        divisor
//   Quo      quotient, registered, updated only on entry to DONE
//   Rem      remainder, registered, updated only on entry to DONE
//   Busy     high while iterating
//   Done     one-cycle pulse, Quo/Rem/DivZero valid
//   DivZero  registered flag, last accepted operation had B == 0

module div_restoring_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quo,
    output logic [WIDTH-1:0] Rem,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    // The dividend register doubles as the quotient register: each iteration
    // shifts a dividend bit out at the MSB and a quotient bit in at the LSB.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   p;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   p_nx;
    logic [WIDTH-1:0] dvd_nx;
    logic             qbit;
    logic             last;

    // One trial subtraction per cycle; a negative difference (MSB set) restores.
    always_comb begin
        p_sh   = {p[WIDTH-1:0], dvd[WIDTH-1]};
        diff   = p_sh + ~{1'b0, dsr} + {{WIDTH{1'b0}}, 1'b1};
        qbit   = ~diff[WIDTH];
        p_nx   = qbit ? diff : p_sh;
        dvd_nx = {dvd[WIDTH-2:0], qbit};
        last   = (cnt == CW'(1));
    end

    always_comb begin
        state_nx = state;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nx = (B == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                Done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            dvd     <= '0;
            dsr     <= '0;
            p       <= '0;
            cnt     <= '0;
            Quo     <= '0;
            Rem     <= '0;
            DivZero <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (B == '0) begin
                            Quo     <= '1;
                            Rem     <= A;
                            DivZero <= 1'b1;
                        end else begin
                            dvd <= A;
                            dsr <= B;
                            p   <= '0;
                            cnt <= CW'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    p   <= p_nx;
                    dvd <= dvd_nx;
                    cnt <= cnt - CW'(1);
                    // Results are taken from the final iteration's next values
                    // so they appear in the same cycle as Done.
                    if (last) begin
                        Quo     <= dvd_nx;
                        Rem     <= p_nx[WIDTH-1:0];
                        DivZero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_restoring_4.sv
// tb/tb_div_restoring_4.sv - self-checking bench for div_restoring_4

module tb_div_restoring_4;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] a, b, quo, rem;
    logic       busy, done, divzero;

    logic       start8;
    logic [7:0] a8, b8, quo8, rem8;
    logic       busy8, done8, divzero8;

    int n_checks;
    int n_fail;

    div_restoring_4 #(.WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .Start(start), .A(a), .B(b),
        .Quo(quo), .Rem(rem), .Busy(busy), .Done(done), .DivZero(divzero)
    );

    div_restoring_4 #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .Start(start8), .A(a8), .B(b8),
        .Quo(quo8), .Rem(rem8), .Busy(busy8), .Done(done8), .DivZero(divzero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Starts one WIDTH=4 operation from IDLE (called #1 after an edge) and
    // returns #1 after the edge that ends the Done cycle, back in IDLE.
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] qe,
                         input logic [3:0] re, input logic dze, input string tag);
        int lat;
        int bcnt;
        a = ta; b = tb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ta; b = ~tb;
        lat = 0; bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, " latency"}, lat, (tb == 0) ? 0 : 4);
        check_eq({tag, " busy cycles"}, bcnt, (tb == 0) ? 0 : 4);
        check_eq({tag, " quo"}, quo, qe);
        check_eq({tag, " rem"}, rem, re);
        check_eq({tag, " divzero"}, divzero, dze);
        check_eq({tag, " busy at done"}, busy, 0);
        @(posedge clk); #1;
        check_eq({tag, " done falls"}, done, 0);
        check_eq({tag, " quo holds"}, quo, qe);
    endtask

    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb);
        int lat;
        logic [7:0] qe, re;
        qe = (tb == 0) ? 8'hff : ta / tb;
        re = (tb == 0) ? ta : ta % tb;
        a8 = ta; b8 = tb; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq($sformatf("w8 %0d/%0d latency", ta, tb), lat, (tb == 0) ? 0 : 8);
        check_eq($sformatf("w8 %0d/%0d quo", ta, tb), quo8, qe);
        check_eq($sformatf("w8 %0d/%0d rem", ta, tb), rem8, re);
        check_eq($sformatf("w8 %0d/%0d divzero", ta, tb), divzero8, (tb == 0) ? 1 : 0);
        @(posedge clk); #1;
        check_eq($sformatf("w8 %0d/%0d done falls", ta, tb), done8, 0);
    endtask

    logic [3:0] ha [18];
    logic [3:0] hb [18];
    logic [3:0] hq [3];
    logic [3:0] hr [3];

    initial begin
        int ndone;
        n_checks = 0; n_fail = 0;
        reset_n = 1'b0; start = 1'b0; a = '0; b = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        ha = '{13, 5, 7, 1, 9, 2, 11, 0, 3, 8, 6, 4, 15, 12, 10, 14, 3, 5};
        hb = '{ 3, 0, 2, 7, 1, 6,  4, 9, 5, 2, 8, 3,  2,  7,  1, 11, 0, 6};
        hq = '{4, 2, 7};
        hr = '{1, 3, 1};

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset quo", quo, 0);
        check_eq("reset rem", rem, 0);
        check_eq("reset busy", busy, 0);
        check_eq("reset done", done, 0);
        check_eq("reset divzero", divzero, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_op(13, 3, 4, 1, 0, "13/3");
        do_op(15, 1, 15, 0, 0, "15/1");
        do_op(7, 9, 0, 7, 0, "7/9");
        do_op(9, 0, 15, 9, 1, "9/0");
        do_op(6, 2, 3, 0, 0, "6/2");

        // Start held high, operands changing every cycle: only v0, v6, v12 are accepted.
        ndone = 0;
        for (int k = 0; k < 18; k++) begin
            a = ha[k]; b = hb[k]; start = 1'b1;
            @(posedge clk); #1;
            if (done) begin
                if (ndone < 3) begin
                    check_eq($sformatf("held op%0d cycle", ndone), k, ndone * 6 + 4);
                    check_eq($sformatf("held op%0d quo", ndone), quo, hq[ndone]);
                    check_eq($sformatf("held op%0d rem", ndone), rem, hr[ndone]);
                    check_eq($sformatf("held op%0d divzero", ndone), divzero, 0);
                end
                ndone++;
            end
        end
        start = 1'b0;
        check_eq("held done count", ndone, 3);
        @(posedge clk); #1;

        // Reset during the second RUN cycle aborts the operation.
        a = 14; b = 5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_eq("abort quo", quo, 0);
        check_eq("abort rem", rem, 0);
        check_eq("abort busy", busy, 0);
        check_eq("abort done", done, 0);
        check_eq("abort divzero", divzero, 0);
        ndone = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check_eq("abort no done", ndone, 0);
        do_op(14, 5, 2, 4, 0, "14/5");

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [3:0] ia, jb;
                ia = 4'(i); jb = 4'(j);
                do_op(ia, jb, (j == 0) ? 4'hf : 4'(i / j), (j == 0) ? ia : 4'(i % j),
                      (j == 0), $sformatf("sweep %0d/%0d", i, j));
            end
        end

        do_op8(8'd200, 8'd0);
        do_op8(8'd255, 8'd1);
        do_op8(8'd200, 8'd7);
        for (int i = 0; i < 40; i++) begin
            do_op8(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
